// File: rtl/phase_cmd_pkg.sv
// Shared opcodes and FSM state encoding for the phase command loader.
package phase_cmd_pkg;

    localparam logic [7:0] OP_SET_OFF = 8'h01;
    localparam logic [7:0] OP_SET_DIV = 8'h02;
    localparam logic [7:0] OP_COMMIT  = 8'h03;
    localparam logic [7:0] OP_OE_ON   = 8'h04;
    localparam logic [7:0] OP_OE_OFF  = 8'h05;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GET_CH = 3'd1,
        ST_GET_HI = 3'd2,
        ST_GET_LO = 3'd3,
        ST_SKIP2  = 3'd4,
        ST_SKIP1  = 3'd5,
        ST_RELOAD = 3'd6
    } state_e;

endpackage

// File: rtl/phase_cmd_loader_offset_bank.sv
// Per-channel offset storage: shadow registers written by SET_OFF,
// copied wholesale into the active bus on a commit strobe.
module offset_bank #(
    parameter int N_CH         = 64,
    parameter int OFFSET_WIDTH = 11,
    parameter int IDX_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en_i,
    input  logic [IDX_W-1:0]             wr_idx_i,
    input  logic [OFFSET_WIDTH-1:0]      wr_data_i,
    input  logic                         commit_i,
    output logic [N_CH*OFFSET_WIDTH-1:0] active_o
);

    logic [OFFSET_WIDTH-1:0]      shadow_q [N_CH];
    logic [N_CH*OFFSET_WIDTH-1:0] active_q;

    // Shadow registers: cleared on reset, single-entry write per accepted SET_OFF.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_CH; k++) begin
                shadow_q[k] <= '0;
            end
        end else if (wr_en_i) begin
            shadow_q[wr_idx_i] <= wr_data_i;
        end
    end

    // Active registers: the clock bank only ever sees values copied on commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= '0;
        end else if (commit_i) begin
            for (int k = 0; k < N_CH; k++) begin
                active_q[k*OFFSET_WIDTH +: OFFSET_WIDTH] <= shadow_q[k];
            end
        end
    end

    assign active_o = active_q;

endmodule

// File: rtl/phase_cmd_loader.sv
// Byte-command front end for the transducer clock bank: parses the UART
// byte stream, stages offsets/divider in shadow registers and applies them
// atomically on COMMIT followed by an active-low reload strobe.
// OFFSET_WIDTH is expected to lie in 10..16 so one hi byte plus one lo byte
// cover both the offset and the divider fields.
module phase_cmd_loader
    import phase_cmd_pkg::*;
#(
    parameter int N_CH           = 64,
    parameter int OFFSET_WIDTH   = 11,
    parameter int RELOAD_CYCLES  = 4,
    parameter int DEFAULT_DIVIDE = 624
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_valid,
    output logic                         rx_ready,
    output logic [N_CH*OFFSET_WIDTH-1:0] offsets,
    output logic [OFFSET_WIDTH-2:0]      divide,
    output logic                         oe,
    output logic                         ch_rst_n,
    output logic                         err
);

    localparam int DIV_W = OFFSET_WIDTH - 1;
    localparam int HI_W  = OFFSET_WIDTH - 8;
    localparam int CNT_W = $clog2(RELOAD_CYCLES + 1);
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [DIV_W-1:0] DEF_DIV  = DIV_W'(DEFAULT_DIVIDE);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RELOAD_CYCLES);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  ch_q, ch_d;
    logic [HI_W-1:0]   hi_q, hi_d;
    logic              is_div_q, is_div_d;
    logic              oe_q, oe_d;
    logic              err_q, err_d;
    logic              rx_ready_q, rx_ready_d;
    logic              ch_rst_n_q, ch_rst_n_d;
    logic [DIV_W-1:0]  shadow_div_q, shadow_div_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              accept_s;
    logic              bank_wr_s;
    logic              commit_s;

    assign accept_s = rx_valid && rx_ready_q;

    // Command parser: next state, shadow/active divider, oe and error pulse.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ch_d         = ch_q;
        hi_d         = hi_q;
        is_div_d     = is_div_q;
        oe_d         = oe_q;
        err_d        = 1'b0;
        shadow_div_d = shadow_div_q;
        div_d        = div_q;
        bank_wr_s    = 1'b0;
        commit_s     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    case (rx_data)
                        OP_SET_OFF: begin
                            state_d  = ST_GET_CH;
                            is_div_d = 1'b0;
                        end
                        OP_SET_DIV: begin
                            state_d  = ST_GET_HI;
                            is_div_d = 1'b1;
                        end
                        OP_COMMIT: begin
                            state_d  = ST_RELOAD;
                            cnt_d    = CNT_LOAD;
                            commit_s = 1'b1;
                            div_d    = shadow_div_q;
                        end
                        OP_OE_ON:  oe_d  = 1'b1;
                        OP_OE_OFF: oe_d  = 1'b0;
                        default:   err_d = 1'b1;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GET_CH: begin
                if (accept_s) begin
                    // Out-of-range channel: flag it and swallow the two data bytes.
                    if ({1'b0, rx_data} < 9'(N_CH)) begin
                        ch_d    = rx_data[IDX_W-1:0];
                        state_d = ST_GET_HI;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_SKIP2;
                    end
                end else begin
                    state_d = ST_GET_CH;
                end
            end
            ST_GET_HI: begin
                if (accept_s) begin
                    hi_d    = rx_data[HI_W-1:0];
                    state_d = ST_GET_LO;
                end else begin
                    state_d = ST_GET_HI;
                end
            end
            ST_GET_LO: begin
                if (accept_s) begin
                    if (is_div_q) begin
                        shadow_div_d = {hi_q[HI_W-2:0], rx_data};
                    end else begin
                        bank_wr_s = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GET_LO;
                end
            end
            ST_SKIP2: begin
                if (accept_s) begin
                    state_d = ST_SKIP1;
                end else begin
                    state_d = ST_SKIP2;
                end
            end
            ST_SKIP1: begin
                if (accept_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SKIP1;
                end
            end
            ST_RELOAD: begin
                // Counter holds the low cycles still owed; leave as the last one ends.
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rx_ready_d = (state_d != ST_RELOAD);
        ch_rst_n_d = (state_d != ST_RELOAD);
    end

    // State and control registers; reset parks the FSM in RELOAD so the
    // bank is reloaded from the default values once reset is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RELOAD;
            cnt_q        <= CNT_LOAD;
            ch_q         <= '0;
            hi_q         <= '0;
            is_div_q     <= 1'b0;
            oe_q         <= 1'b0;
            err_q        <= 1'b0;
            rx_ready_q   <= 1'b0;
            ch_rst_n_q   <= 1'b0;
            shadow_div_q <= DEF_DIV;
            div_q        <= DEF_DIV;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ch_q         <= ch_d;
            hi_q         <= hi_d;
            is_div_q     <= is_div_d;
            oe_q         <= oe_d;
            err_q        <= err_d;
            rx_ready_q   <= rx_ready_d;
            ch_rst_n_q   <= ch_rst_n_d;
            shadow_div_q <= shadow_div_d;
            div_q        <= div_d;
        end
    end

    offset_bank #(
        .N_CH         (N_CH),
        .OFFSET_WIDTH (OFFSET_WIDTH),
        .IDX_W        (IDX_W)
    ) u_offset_bank (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (bank_wr_s),
        .wr_idx_i  (ch_q),
        .wr_data_i ({hi_q, rx_data}),
        .commit_i  (commit_s),
        .active_o  (offsets)
    );

    assign rx_ready = rx_ready_q;
    assign ch_rst_n = ch_rst_n_q;
    assign divide   = div_q;
    assign oe       = oe_q;
    assign err      = err_q;

endmodule

// File: tb/tb_phase_cmd_loader.sv
// Randomised and directed bench for phase_cmd_loader against a
// command-level reference model.
module tb_phase_cmd_loader;

    localparam int N_CH = 64;
    localparam int OW   = 11;
    localparam int RC   = 4;
    localparam int DD   = 624;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic [N_CH*OW-1:0]   offsets;
    logic [OW-2:0]        divide;
    logic                 oe;
    logic                 ch_rst_n;
    logic                 err;

    always #5 clk = ~clk;

    phase_cmd_loader #(
        .N_CH(N_CH), .OFFSET_WIDTH(OW), .RELOAD_CYCLES(RC), .DEFAULT_DIVIDE(DD)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .offsets(offsets), .divide(divide), .oe(oe),
        .ch_rst_n(ch_rst_n), .err(err)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state (command level)
    logic [OW-1:0] m_sh  [N_CH];
    logic [OW-1:0] m_act [N_CH];
    int            m_sdiv, m_adiv;
    bit            m_oe, m_err;
    int            m_busy;
    int            cmdq[$];

    task automatic check_eq(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N_CH*OW-1:0] act_bus();
        logic [N_CH*OW-1:0] b;
        for (int k = 0; k < N_CH; k++) b[k*OW +: OW] = m_act[k];
        return b;
    endfunction

    task automatic model_byte(input int b);
        cmdq.push_back(b);
        case (cmdq[0])
            1: begin
                if (cmdq.size() == 2 && cmdq[1] >= N_CH) m_err = 1'b1;
                if (cmdq.size() == 4) begin
                    if (cmdq[1] < N_CH) m_sh[cmdq[1]] = OW'((cmdq[2] * 256 + cmdq[3]) % (1 << OW));
                    cmdq.delete();
                end
            end
            2: begin
                if (cmdq.size() == 3) begin
                    m_sdiv = (cmdq[1] * 256 + cmdq[2]) % (1 << (OW - 1));
                    cmdq.delete();
                end
            end
            3: begin
                for (int k = 0; k < N_CH; k++) m_act[k] = m_sh[k];
                m_adiv = m_sdiv;
                m_busy = RC;
                cmdq.delete();
            end
            4: begin m_oe = 1'b1; cmdq.delete(); end
            5: begin m_oe = 1'b0; cmdq.delete(); end
            default: begin m_err = 1'b1; cmdq.delete(); end
        endcase
    endtask

    // Advance the model by one clock edge using the inputs about to be sampled.
    task automatic model_step();
        m_err = 1'b0;
        if (rst) begin
            for (int k = 0; k < N_CH; k++) begin m_sh[k] = '0; m_act[k] = '0; end
            m_sdiv = DD; m_adiv = DD; m_oe = 1'b0; m_busy = RC;
            cmdq.delete();
        end else if (m_busy > 0) begin
            m_busy--;
        end else if (rx_valid) begin
            model_byte(int'(rx_data));
        end
    endtask

    task automatic do_checks();
        check_eq("rx_ready", rx_ready, (m_busy == 0));
        check_eq("ch_rst_n", ch_rst_n, (m_busy == 0));
        check_eq("oe", oe, m_oe);
        check_eq("err", err, m_err);
        check_eq("divide", divide, m_adiv);
        check_eq("offsets", offsets, act_bus());
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        do_checks();
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        repeat (n) cycle();
    endtask

    task automatic send(input logic [7:0] b);
        bit ok = 1'b0;
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (m_busy == 0) ok = 1'b1;
            cycle();
        end
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        if (!ok) check_eq("send_timeout", 1'b0, 1'b1);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        rx_valid = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        logic [N_CH*OW-1:0] masked;
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        model_step();
        @(posedge clk); @(negedge clk);
        cycle();
        rst = 1'b0;

        // 1: reset values and reload window after release
        check_eq("rst_div", divide, 10'd624);
        check_eq("rst_off", offsets, '0);
        check_eq("rst_ready", rx_ready, 1'b0);
        n = 0;
        while (ch_rst_n == 1'b0 && n < 20) begin n++; cycle(); end
        check_eq("rst_low_cycles", n, RC);
        check_eq("rst_ready_up", rx_ready, 1'b1);

        // 2: SET_OFF ch5 = 0x271, then COMMIT
        send(8'h01); send(8'h05); send(8'h02); send(8'h71);
        check_eq("t2_pre_commit", offsets, '0);
        send(8'h03);
        check_eq("t2_ch5", offsets[5*OW +: OW], 11'h271);
        masked = offsets;
        masked[5*OW +: OW] = '0;
        check_eq("t2_others", masked, '0);
        n = 0;
        while (rx_ready == 1'b0 && n < 20) begin n++; cycle(); end
        check_eq("t2_reload_cycles", n, RC);

        // 3: invalid channel, OE_ON, COMMIT
        reset_dut();
        idle(RC + 1);
        send(8'h01); send(8'h40);
        check_eq("t3_err", err, 1'b1);
        send(8'hAA); send(8'hBB);
        send(8'h04);
        check_eq("t3_oe", oe, 1'b1);
        check_eq("t3_no_reload", ch_rst_n, 1'b1);
        send(8'h03);
        check_eq("t3_offsets", offsets, '0);

        // 4: unknown opcode, then SET_DIV 0x1F3 + COMMIT
        send(8'h7F);
        check_eq("t4_err", err, 1'b1);
        idle(1);
        check_eq("t4_err_clear", err, 1'b0);
        send(8'h02); send(8'h01); send(8'hF3); send(8'h03);
        check_eq("t4_div", divide, 10'h1F3);

        // 5: reset mid-command, next byte is an opcode
        send(8'h01); send(8'h05); send(8'h02); send(8'h71);
        send(8'h01); send(8'h05);
        reset_dut();
        send(8'h03);
        check_eq("t5_offsets", offsets, '0);
        check_eq("t5_reload", ch_rst_n, 1'b0);
        idle(RC);

        // 6: random command stream with gaps and bytes offered during reload
        for (int c = 0; c < 250; c++) begin
            int t;
            t = $urandom_range(0, 9);
            idle($urandom_range(0, 2));
            case (t)
                0, 1, 2, 3: begin
                    send(8'h01); idle($urandom_range(0, 2));
                    send(8'($urandom_range(0, 70))); idle($urandom_range(0, 2));
                    send(8'($urandom)); idle($urandom_range(0, 2));
                    send(8'($urandom));
                end
                4: begin
                    send(8'h02); send(8'($urandom)); idle($urandom_range(0, 2)); send(8'($urandom));
                end
                5, 6: send(8'h03);
                7: send(8'h04);
                8: send(8'h05);
                default: send(8'($urandom_range(6, 255)));
            endcase
        end
        send(8'h03);
        idle(RC + 2);
        check_eq("final_offsets", offsets, act_bus());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
